// File: rtl/comparador_serial_n.sv
`default_nettype none
// ============================================================================
// Module   : comparador_serial_n
// Brief    : Digit-serial N-bit magnitude comparator (MSB digit first) with
//            signed mode, 7485-style cascade inputs and start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module comparador_serial_n #(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         sinal,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         ALBi,
  input  logic         AGBi,
  input  logic         AEBi,
  output logic         ALBo,
  output logic         AGBo,
  output logic         AEBo,
  output logic         pronto,
  output logic         ocupado
);

  localparam int c_ND = N / D;
  localparam int c_IW = (c_ND > 1) ? $clog2(c_ND) : 1;

  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(c_ND - 1);
  localparam logic [c_IW-1:0] c_IDX_ZERO = '0;
  localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);

  localparam logic [1:0] c_OCIOSO  = 2'd0;
  localparam logic [1:0] c_COMPARA = 2'd1;
  localparam logic [1:0] c_FIM     = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [c_IW-1:0] idx_q, idx_d;
  logic [2:0]      res_q, res_d;      // {ALB, AGB, AEB}
  logic [N-1:0]    a_q, b_q;
  logic            sinal_q;
  logic [2:0]      casc_q;

  logic            w_load;
  logic [D-1:0]    w_dig_a [c_ND];
  logic [D-1:0]    w_dig_b [c_ND];
  logic [D-1:0]    w_da, w_db;
  logic            w_lt, w_eq;

  assign w_load = (state_q == c_OCIOSO) && iniciar;

  for (genvar g = 0; g < c_ND; g++) begin : g_digit
    assign w_dig_a[g] = a_q[g*D +: D];
    assign w_dig_b[g] = b_q[g*D +: D];
  end

  // Signed mode: flipping the sign bit of the top digit turns two's-complement
  // ordering into plain unsigned ordering (offset binary).
  always_comb begin
    w_da = w_dig_a[idx_q];
    w_db = w_dig_b[idx_q];
    if (sinal_q && (idx_q == c_IDX_LAST)) begin
      w_da[D-1] = ~w_da[D-1];
      w_db[D-1] = ~w_db[D-1];
    end
    w_lt = (w_da < w_db);
    w_eq = (w_da == w_db);
  end

  // Operand capture: only on the start edge, so later input changes are inert.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sinal_q <= 1'b0;
      casc_q  <= 3'b000;
    end else if (w_load) begin
      a_q     <= A;
      b_q     <= B;
      sinal_q <= sinal;
      casc_q  <= {ALBi, AGBi, AEBi};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= c_OCIOSO;
      idx_q   <= c_IDX_LAST;
      res_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      c_OCIOSO: begin
        if (iniciar) begin
          state_d = c_COMPARA;
          idx_d   = c_IDX_LAST;
        end
      end
      c_COMPARA: begin
        if (!w_eq) begin
          res_d   = {w_lt, ~w_lt, 1'b0};
          state_d = c_FIM;
        end else if (idx_q == c_IDX_ZERO) begin
          res_d   = casc_q;
          state_d = c_FIM;
        end else begin
          idx_d = idx_q - c_IDX_ONE;
        end
      end
      c_FIM: begin
        state_d = c_OCIOSO;
      end
      default: begin
        state_d = c_OCIOSO;
      end
    endcase
  end

  always_comb begin
    pronto  = (state_q == c_FIM);
    ocupado = (state_q != c_OCIOSO);
    ALBo    = res_q[2];
    AGBo    = res_q[1];
    AEBo    = res_q[0];
  end

endmodule
`default_nettype wire

// File: tb/tb_comparador_serial_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparador_serial_n
// Brief    : Directed and model-checked bench for three comparator widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparador_serial_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ini;
  logic        sinal;
  logic [31:0] opa, opb;
  logic        albi, agbi, aebi;
  int          sel;

  logic [2:0]  res8, res16, res32;
  logic        pr8, pr16, pr32, oc8, oc16, oc32;
  logic [2:0]  res_m;
  logic        pr_m, oc_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  comparador_serial_n #(.N(8), .D(2)) u_dut8 (
    .clock(clk), .reset(rst), .iniciar(ini[0]), .sinal(sinal),
    .A(opa[7:0]), .B(opb[7:0]), .ALBi(albi), .AGBi(agbi), .AEBi(aebi),
    .ALBo(res8[2]), .AGBo(res8[1]), .AEBo(res8[0]), .pronto(pr8), .ocupado(oc8)
  );

  comparador_serial_n #(.N(16), .D(4)) u_dut16 (
    .clock(clk), .reset(rst), .iniciar(ini[1]), .sinal(sinal),
    .A(opa[15:0]), .B(opb[15:0]), .ALBi(albi), .AGBi(agbi), .AEBi(aebi),
    .ALBo(res16[2]), .AGBo(res16[1]), .AEBo(res16[0]), .pronto(pr16), .ocupado(oc16)
  );

  comparador_serial_n #(.N(32), .D(8)) u_dut32 (
    .clock(clk), .reset(rst), .iniciar(ini[2]), .sinal(sinal),
    .A(opa), .B(opb), .ALBi(albi), .AGBi(agbi), .AEBi(aebi),
    .ALBo(res32[2]), .AGBo(res32[1]), .AEBo(res32[0]), .pronto(pr32), .ocupado(oc32)
  );

  always_comb begin
    res_m = res16;
    pr_m  = pr16;
    oc_m  = oc16;
    case (sel)
      0:       begin res_m = res8;  pr_m = pr8;  oc_m = oc8;  end
      2:       begin res_m = res32; pr_m = pr32; oc_m = oc32; end
      default: begin res_m = res16; pr_m = pr16; oc_m = oc16; end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // perturb: 1 = overwrite B after the start edge, 2 = pulse iniciar in COMPARA
  task automatic run(input string tag, input int s, input logic [31:0] a, input logic [31:0] b,
                     input logic sg, input logic [2:0] cas, input int perturb,
                     input logic [2:0] exp_res, input int exp_k);
    logic [2:0] res;
    logic       done;
    int         k;
    @(negedge clk);
    sel = s;
    opa = a;
    opb = b;
    sinal = sg;
    {albi, agbi, aebi} = cas;
    ini[s] = 1'b1;
    @(posedge clk);
    #1;
    ini[s] = 1'b0;
    k = 0;
    done = 1'b0;
    res = 3'b000;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (pr_m) begin
        done = 1'b1;
        res = res_m;
        break;
      end
      k++;
      if (perturb == 1 && k == 1) opb = 32'hFFFF_FFFF;
      if (perturb == 2) ini[s] = (k == 1);
    end
    ini[s] = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_res"}, 64'(res), 64'(exp_res));
    chk({tag, "_k"}, 64'(k), 64'(exp_k));
    @(negedge clk);
    chk({tag, "_idle"}, 64'({pr_m, oc_m}), 64'd0);
  endtask

  function automatic void model(input int n, input int d, input logic [31:0] a, input logic [31:0] b,
                                input logic sg, input logic [2:0] cas,
                                output logic [2:0] res, output int k);
    longint sa, sb;
    logic [31:0] x;
    int p;
    sa = longint'(a);
    sb = longint'(b);
    if (sg) begin
      if (a[n-1]) sa = sa - (longint'(1) << n);
      if (b[n-1]) sb = sb - (longint'(1) << n);
    end
    if (sa < sb)      res = 3'b100;
    else if (sa > sb) res = 3'b010;
    else              res = cas;
    x = a ^ b;
    if (x == 32'd0) begin
      k = n / d;
    end else begin
      p = 0;
      for (int i = 0; i < n; i++) if (x[i]) p = i;
      k = (n - 1 - p) / d + 1;
    end
  endfunction

  initial begin
    logic [2:0]  mres;
    logic [31:0] a, b, mask;
    logic        seen;
    int          mk, n, d;

    rst = 1'b1;
    ini = 3'b000;
    sinal = 1'b0;
    opa = '0;
    opb = '0;
    {albi, agbi, aebi} = 3'b000;
    sel = 1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset_out%0d", s), 64'({res_m, pr_m, oc_m}), 64'd0);
    end
    rst = 1'b0;
    sel = 1;

    run("early_gt",   1, 32'hA000, 32'h9FFF, 1'b0, 3'b001, 0, 3'b010, 1);
    run("late_lt",    1, 32'h1230, 32'h1231, 1'b0, 3'b001, 1, 3'b100, 4);
    run("signed_lt",  1, 32'h8000, 32'h0001, 1'b1, 3'b001, 0, 3'b100, 1);
    run("unsig_gt",   1, 32'h8000, 32'h0001, 1'b0, 3'b001, 0, 3'b010, 1);
    run("casc_lt",    1, 32'h5A5A, 32'h5A5A, 1'b0, 3'b100, 2, 3'b100, 4);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | pr_m;
    end
    chk("casc_no_second_pronto", 64'(seen), 64'd0);
    run("casc_gt",    1, 32'h5A5A, 32'h5A5A, 1'b0, 3'b010, 0, 3'b010, 4);

    // Abandon a comparison two cycles in; result registers still hold 010.
    @(negedge clk);
    sel = 1;
    opa = 32'h1234;
    opb = 32'h1235;
    sinal = 1'b0;
    ini[1] = 1'b1;
    @(posedge clk);
    #1;
    ini[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", 64'(oc_m), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", 64'({res_m, pr_m, oc_m}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | pr_m | oc_m;
    end
    chk("rst_no_pronto", 64'(seen), 64'd0);
    run("after_rst_eq", 1, 32'h00FF, 32'h00FF, 1'b0, 3'b001, 0, 3'b001, 4);

    run("n8_signed",  0, 32'h80, 32'h7F, 1'b1, 3'b001, 0, 3'b100, 1);
    run("n32_eq",     2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b010, 0, 3'b010, 4);

    for (int s = 0; s < 3; s += 2) begin
      n = (s == 0) ? 8 : 32;
      d = (s == 0) ? 2 : 8;
      mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      for (int mode = 0; mode < 2; mode++) begin
        for (int i = 0; i < 200; i++) begin
          a = $urandom & mask;
          case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = a;
            2:       b = a ^ (32'd1 << $urandom_range(0, n - 1));
            default: b = a ^ ($urandom & ((32'd1 << $urandom_range(0, n - 1)) - 32'd1));
          endcase
          b = b & mask;
          mres = 3'($urandom_range(0, 7));
          model(n, d, a, b, mode[0], mres, mres, mk);
          run($sformatf("sw%0d_m%0d_%0d", n, mode, i), s, a, b, mode[0],
              {albi, agbi, aebi} ^ {albi, agbi, aebi} ^ mres_cas(a, b, mres), 0, mres, mk);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Recovers the cascade vector used for the model call: for equal operands the
  // model result is the cascade input itself; otherwise any one-hot value works.
  function automatic logic [2:0] mres_cas(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] r);
    mres_cas = (a == b) ? r : 3'b001;
  endfunction

endmodule
`default_nettype wire

// File: doc/comparador_serial_n.md
# comparador_serial_n

Sequential, parametrised magnitude comparator. It compares two N-bit operands one D-bit digit per clock, starting at the most significant digit, and stops at the first unequal digit. It supports unsigned and two's-complement modes, 7485-style cascade inputs, and a start/done handshake. It is used wherever wide operands (scores, timers, memory addresses in the game datapath) are compared without a wide combinational chain.

## Interface
Parameters:
- N, 16: operand width in bits; must be a multiple of D, N ≥ D.
- D, 4: digit width compared per cycle; number of digits ND = N/D.

Ports:
- clock  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- iniciar  input  1  start request; sampled only in state OCIOSO.
- sinal  input  1  mode: 0 = unsigned, 1 = two's-complement signed.
- A  input  N  operand A; sampled with iniciar.
- B  input  N  operand B; sampled with iniciar.
- ALBi, AGBi, AEBi  input  1 each  cascade inputs; sampled with iniciar.
- ALBo, AGBo, AEBo  output  1 each  registered result: A<B, A>B, A=B.
- pronto  output  1  one-cycle done pulse.
- ocupado  output  1  high whenever the state is not OCIOSO.

## Operation
- States: OCIOSO, COMPARA, FIM.
- OCIOSO, iniciar=1:
  - Latch A, B, sinal, ALBi/AGBi/AEBi.
  - Set the digit index to ND-1.
  - Go to COMPARA.
- OCIOSO, iniciar=0: stay.
- COMPARA, each edge, examines digit [index*D+D-1 : index*D] of the latched operands.
  - In signed mode, for index = ND-1 only, the MSB of both digits is inverted before comparing (offset binary). All other digits are compared unsigned.
  - Digits differ: ALBo/AGBo take the digit comparison result, AEBo=0, go to FIM.
  - Digits equal and index=0: result = latched cascade inputs (ALBo=ALBi, AGBo=AGBi, AEBo=AEBi) passed through unchanged, go to FIM.
  - Digits equal and index>0: decrement index, stay.
- FIM: pronto=1 for exactly this cycle; next edge goes to OCIOSO unconditionally.
- iniciar is ignored in COMPARA and FIM; there is no queueing.
- Result registers are written only on the COMPARA→FIM edge. They hold until the next result write or reset.
- Changes on A, B, sinal or the cascade inputs after the sampling edge have no effect on the comparison in progress.
- Results are mutually exclusive whenever the cascade inputs are one-hot. Non-one-hot cascade inputs are passed through unmodified.

## Timing
- Reset values: state OCIOSO, ALBo=0, AGBo=0, AEBo=0, pronto=0, ocupado=0, index=ND-1.
- Let k = number of digits examined (1 ≤ k ≤ ND).
  - Edge e0 samples iniciar.
  - Edges e1..ek are in COMPARA; results are valid after ek.
  - pronto is high for the cycle between ek and ek+1.
  - Minimum latency is 1 cycle (MSB digit differs); maximum is ND cycles (equal operands).
- ocupado rises after e0 and falls after ek+1. pronto and ocupado are Moore outputs decoded from state.
- Back-to-back operation: iniciar may be sampled at the edge immediately after FIM (the first OCIOSO cycle). Throughput is at most one comparison per k+2 cycles.
- Reset asserted mid-operation: the comparison is abandoned, outputs return to reset values asynchronously, and no pronto is produced. After release, the first edge with iniciar=1 starts a fresh comparison.
- iniciar held high continuously: a new comparison starts on each OCIOSO cycle, using the operand values present at that edge.

## Test plan
- Reset mid-compare: N=16, D=4, unsigned, A=16'h1234, B=16'h1235, assert reset two cycles after iniciar. Outputs immediately return to 0/0/0, ocupado=0, no pronto. Then run A=16'h00FF vs B=16'h00FF with cascade 0/0/1: pronto after 4 compare cycles, AEBo=1.
- Early termination, unsigned: A=16'hA000, B=16'h9FFF. Exactly 1 COMPARA cycle, pronto on the next cycle, AGBo=1, ALBo=0, AEBo=0.
- Late difference: A=16'h1230, B=16'h1231. 4 compare cycles, ALBo=1. Changing B to 16'hFFFF during COMPARA does not alter the result.
- Signed mode: sinal=1, A=16'h8000 (-32768), B=16'h0001. ALBo=1 after 1 cycle. With sinal=0 and the same operands, AGBo=1.
- Cascade pass-through: A=B=16'h5A5A, cascade inputs 1/0/0, then 0/1/0. Outputs equal the cascade inputs after 4 cycles; pronto is a single-cycle pulse; iniciar pulsed during COMPARA is ignored (no second pronto).
- Parameter sweep: N=8/D=2 and N=32/D=8, 200 random operand pairs per mode, checked against a reference model for results and for latency k.
